// File: rtl/uart_ram_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_ram_loader
//  Purpose  : Turns framed byte commands from the UART receiver into
//             single-cycle writes to the 256-byte pixel/line RAM, answering
//             every completed frame with an ACK or NAK byte.
//
//             Frame: SYNC, ADDR, DATA, CHK   (good when CHK == ADDR ^ DATA)
//
//  Ports    :
//    clk          in   system clock (50 MHz)
//    rst          in   asynchronous, active-high reset
//    rx_data      in   [7:0] received byte
//    rx_valid     in   one-cycle strobe qualifying rx_data
//    tx_busy      in   transmitter cannot accept a byte
//    tx_start     out  one-cycle transmit request
//    tx_data      out  [7:0] response byte (ACK/NAK), held between requests
//    ram_we       out  one-cycle RAM write enable
//    ram_addr     out  [7:0] RAM write address (registered)
//    ram_data     out  [7:0] RAM write data (registered)
//    frame_count  out  [7:0] good frames, saturating at 255
//    err_count    out  [7:0] checksum failures + timeouts, saturating at 255
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_ram_loader #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter logic [7:0] ACK     = 8'h06,
  parameter logic [7:0] NAK     = 8'h15,
  parameter int         TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic [7:0] frame_count,
  output logic [7:0] err_count
);

  // Idle counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_WRITE = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    ram_addr_q, ram_addr_d;
  logic [7:0]    ram_data_q, ram_data_d;
  logic [7:0]    tx_data_q, tx_data_d;   // doubles as the pending response
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          frame_inc;
  logic          err_inc;

  // --------------------------------------------------------------------------
  // State and data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      ram_addr_q  <= 8'h00;
      ram_data_q  <= 8'h00;
      tx_data_q   <= 8'h00;
      frame_cnt_q <= 8'h00;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // The idle counter defaults to zero, which gives "clear on state entry and
  // on every accepted byte" for free; it only advances while a frame waits.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    addr_d     = addr_q;
    data_d     = data_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    tx_data_d  = tx_data_q;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC)) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = S_DATA;
        end else if (cnt_q == TO_LAST) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = S_CHK;
        end else if (cnt_q == TO_LAST) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == (addr_q ^ data_q)) begin
            // Load the write port now so address/data are stable while
            // ram_we is high in S_WRITE and hold afterwards.
            ram_addr_d = addr_q;
            ram_data_d = data_q;
            state_d    = S_WRITE;
          end else begin
            err_inc   = 1'b1;
            tx_data_d = NAK;
            state_d   = S_RESP;
          end
        end else if (cnt_q == TO_LAST) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WRITE: begin
        frame_inc = 1'b1;
        tx_data_d = ACK;
        state_d   = S_RESP;
      end

      S_RESP: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Saturating status counters
  // --------------------------------------------------------------------------
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_inc && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'h01;
    end
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // Strobes decode straight from the state register: ram_we is the single
  // S_WRITE cycle, tx_start is the S_RESP cycle in which the transmitter is
  // free (leaving S_RESP right after, so it can never repeat back-to-back).
  // --------------------------------------------------------------------------
  assign ram_we      = (state_q == S_WRITE);
  assign tx_start    = (state_q == S_RESP) && !tx_busy;
  assign tx_data     = tx_data_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign frame_count = frame_cnt_q;
  assign err_count   = err_cnt_q;

endmodule
`default_nettype wire
